bias_ctrl: RTL and testbench

BIAS_CTRL -- requirements
Module: bias_ctrl

---
 rtl/bias_ctrl.sv | 117 +++++++++++
 tb/tb_bias_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_ctrl.sv
// Bias fetch sequencer: reads one bias word per output channel from bias memory
// and hands it to the bias adder's register, advancing on the datapath's next pulse.
module bias_ctrl #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 10,
   parameter int RDLAT  = 1
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     start,
   input  logic        [AWIDTH-1:0] base_addr,
   input  logic        [AWIDTH-1:0] num_out,
   input  logic                     next,
   output logic                     mem_re,
   output logic        [AWIDTH-1:0] mem_addr,
   input  logic signed [DWIDTH-1:0] mem_rdata,
   output logic                     breg_we,
   output logic signed [DWIDTH-1:0] read_bias,
   output logic                     busy,
   output logic                     done
);

   localparam int CW = (RDLAT > 1) ? $clog2(RDLAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_DONE} state_t;

   state_t                     state_q, state_d;
   logic        [AWIDTH-1:0]   idx_q, idx_d;
   logic        [AWIDTH-1:0]   base_q, base_d;
   logic        [AWIDTH-1:0]   num_q, num_d;
   logic        [CW-1:0]       wcnt_q, wcnt_d;
   logic signed [DWIDTH-1:0]   rbias_q, rbias_d;
   logic                       bwe_q, bwe_d;

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         num_q   <= '0;
         wcnt_q  <= '0;
         rbias_q <= '0;
         bwe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         num_q   <= num_d;
         wcnt_q  <= wcnt_d;
         rbias_q <= rbias_d;
         bwe_q   <= bwe_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      base_d   = base_q;
      num_d    = num_q;
      wcnt_d   = wcnt_q;
      rbias_d  = rbias_q;
      bwe_d    = 1'b0;
      mem_re   = 1'b0;
      mem_addr = '0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_out != '0) begin
                  base_d  = base_addr;
                  num_d   = num_out;
                  idx_d   = '0;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_FETCH: begin
            mem_re   = 1'b1;
            mem_addr = base_q + idx_q;
            wcnt_d   = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            // Read data is valid only on the last wait cycle; register it then.
            if (wcnt_q == CW'(RDLAT - 1)) begin
               rbias_d = mem_rdata;
               bwe_d   = 1'b1;
               state_d = S_HOLD;
            end else begin
               wcnt_d = wcnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            if (next) begin
               if (idx_q == num_q - AWIDTH'(1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + AWIDTH'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign breg_we   = bwe_q;
   assign read_bias = rbias_q;

endmodule

// File: tb/tb_bias_ctrl.sv
// Scoreboard bench for bias_ctrl: two instances (RDLAT=1 and RDLAT=3), event
// times and values predicted from the sequencing rules, checked by a monitor.
module tb_bias_ctrl;
   localparam int AW = 10;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic xrst = 1'b1;
   always #5 clk = ~clk;

   logic                 start_s    [2];
   logic        [AW-1:0] base_s     [2];
   logic        [AW-1:0] num_s      [2];
   logic                 next_s     [2];
   logic                 mem_re_s   [2];
   logic        [AW-1:0] mem_addr_s [2];
   logic signed [DW-1:0] rdata_s    [2];
   logic                 bwe_s      [2];
   logic signed [DW-1:0] rbias_s    [2];
   logic                 busy_s     [2];
   logic                 done_s     [2];

   bias_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RDLAT(1)) u_dut1 (
      .clk(clk), .xrst(xrst), .start(start_s[0]), .base_addr(base_s[0]), .num_out(num_s[0]),
      .next(next_s[0]), .mem_re(mem_re_s[0]), .mem_addr(mem_addr_s[0]), .mem_rdata(rdata_s[0]),
      .breg_we(bwe_s[0]), .read_bias(rbias_s[0]), .busy(busy_s[0]), .done(done_s[0]));

   bias_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RDLAT(3)) u_dut3 (
      .clk(clk), .xrst(xrst), .start(start_s[1]), .base_addr(base_s[1]), .num_out(num_s[1]),
      .next(next_s[1]), .mem_re(mem_re_s[1]), .mem_addr(mem_addr_s[1]), .mem_rdata(rdata_s[1]),
      .breg_we(bwe_s[1]), .read_bias(rbias_s[1]), .busy(busy_s[1]), .done(done_s[1]));

   // Bias memories; data is random garbage except exactly RDLAT cycles after a read.
   logic signed [DW-1:0] mem [2][1024];
   logic signed [DW-1:0] rp0;
   logic signed [DW-1:0] rp1 [3];
   always @(posedge clk) begin
      rp0    <= mem_re_s[0] ? mem[0][mem_addr_s[0]] : DW'($urandom);
      rp1[0] <= mem_re_s[1] ? mem[1][mem_addr_s[1]] : DW'($urandom);
      rp1[1] <= rp1[0];
      rp1[2] <= rp1[1];
   end
   assign rdata_s[0] = rp0;
   assign rdata_s[1] = rp1[2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int d; int c; int v;} ev_t;
   ev_t q_rd[$];
   ev_t q_ld[$];
   ev_t q_dn[$];
   int  checks = 0;
   int  errors = 0;
   int  busy_cnt [2];

   task automatic check(input bit ok, input string msg);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s", msg);
      end
   endtask

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic check_zero(input int d, input string nm);
      check(!mem_re_s[d] && mem_addr_s[d] == '0 && !bwe_s[d] && rbias_s[d] == '0 &&
            !busy_s[d] && !done_s[d],
            $sformatf("%s dut%0d got re=%0b addr=%0h we=%0b rb=%0d busy=%0b done=%0b required all 0",
                      nm, d, mem_re_s[d], mem_addr_s[d], bwe_s[d], rbias_s[d], busy_s[d], done_s[d]));
   endtask

   // Monitor: every output event must match the next predicted event of its kind.
   ev_t e;
   always @(negedge clk) begin
      if (!xrst) begin
         busy_cnt[0] = 0;
         busy_cnt[1] = 0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (busy_s[d]) busy_cnt[d]++;
            if (mem_re_s[d]) begin
               if (q_rd.size() == 0)
                  check(0, $sformatf("rd dut%0d unexpected read cyc %0d addr %03h required none", d, cyc, mem_addr_s[d]));
               else begin
                  e = q_rd.pop_front();
                  check(e.d == d && e.c == cyc && e.v == int'(mem_addr_s[d]),
                        $sformatf("rd dut%0d got cyc %0d addr %03h required dut%0d cyc %0d addr %03h",
                                  d, cyc, mem_addr_s[d], e.d, e.c, e.v));
               end
            end else begin
               check(mem_addr_s[d] == '0, $sformatf("addr_idle dut%0d cyc %0d got %03h required 0", d, cyc, mem_addr_s[d]));
            end
            if (bwe_s[d]) begin
               if (q_ld.size() == 0)
                  check(0, $sformatf("ld dut%0d unexpected breg_we cyc %0d bias %0d required none", d, cyc, rbias_s[d]));
               else begin
                  e = q_ld.pop_front();
                  check(e.d == d && e.c == cyc && e.v == int'(rbias_s[d]),
                        $sformatf("ld dut%0d got cyc %0d bias %0d required dut%0d cyc %0d bias %0d",
                                  d, cyc, rbias_s[d], e.d, e.c, e.v));
               end
            end
            if (done_s[d]) begin
               if (q_dn.size() == 0)
                  check(0, $sformatf("done dut%0d unexpected cyc %0d required none", d, cyc));
               else begin
                  e = q_dn.pop_front();
                  check(e.d == d && e.c == cyc && e.v == busy_cnt[d],
                        $sformatf("done dut%0d got cyc %0d busy_cycles %0d required dut%0d cyc %0d busy_cycles %0d",
                                  d, cyc, busy_cnt[d], e.d, e.c, e.v));
               end
               busy_cnt[d] = 0;
            end
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_abort(input int d);
      start_s[d] = 1'b0;
      next_s[d]  = 1'b0;
      #1 xrst = 1'b0;
      #1 check_zero(d, "async_rst");
      q_rd.delete();
      q_ld.delete();
      q_dn.delete();
      @(posedge clk);
      @(posedge clk);
      #2 xrst = 1'b1;
      @(posedge clk);
      #1 idle(4);
   endtask

   // One sequence: predict every event time from start, fixed or random next
   // delays, then replay the stimulus cycle by cycle (optionally with noise).
   task automatic run_seq(input int d, input int base, input int n, input int dly,
                          input bit noise, input bit abort);
      int s, t, r, b, dk, a, done_c, abort_c;
      int hb [16];
      int he [16];
      bit in_hold;
      bit is_nxt;
      s = cyc;
      t = s + 1;
      abort_c = -1;
      for (int k = 0; k < n; k++) begin
         r = t;
         a = (base + k) % 1024;
         q_rd.push_back('{d, r, a});
         b = r + 1 + lat(d);
         q_ld.push_back('{d, b, int'(mem[d][a])});
         dk = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
         hb[k] = b;
         he[k] = b + dk;
         t = b + dk + 1;
         if (abort && k == 1) abort_c = r + 1 + ((lat(d) > 1) ? 1 : 0);
      end
      done_c = (n == 0) ? s + 1 : t;
      q_dn.push_back('{d, done_c, done_c - s});
      for (int c = s; c <= done_c; c++) begin
         if (c == abort_c) begin
            do_abort(d);
            return;
         end
         in_hold = 1'b0;
         is_nxt  = 1'b0;
         for (int k = 0; k < n; k++) begin
            if (c >= hb[k] && c <= he[k]) in_hold = 1'b1;
            if (c == he[k]) is_nxt = 1'b1;
         end
         start_s[d] = (c == s) || (noise && c > s && $urandom_range(0, 3) == 0);
         base_s[d]  = (c == s) ? AW'(base) : AW'($urandom);
         num_s[d]   = (c == s) ? AW'(n) : AW'($urandom);
         next_s[d]  = is_nxt || (noise && !in_hold && $urandom_range(0, 2) == 0);
         @(posedge clk);
         #1;
      end
      start_s[d] = 1'b0;
      next_s[d]  = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d required finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         next_s[d]  = 1'b0;
         base_s[d]  = '0;
         num_s[d]   = '0;
         for (int a = 0; a < 1024; a++) mem[d][a] = DW'($urandom);
      end
      mem[0][16] = 16'sd5;
      mem[0][17] = -16'sd3;
      mem[0][18] = 16'sd7;
      mem[1][1023] = -16'sd32768;
      #1 xrst = 1'b0;
      #2 check_zero(0, "reset");
      check_zero(1, "reset");
      @(posedge clk);
      #2 xrst = 1'b1;
      @(posedge clk);
      #1;
      run_seq(0, 'h010, 3, 2, 0, 0);
      idle(2);
      run_seq(0, 'h123, 0, 0, 0, 0);
      idle(1);
      run_seq(1, 'h055, 0, 0, 0, 0);
      idle(2);
      run_seq(1, 'h3FF, 1, -1, 0, 0);
      idle(1);
      run_seq(0, 'h3FE, 3, -1, 0, 0);
      run_seq(1, 'h3FE, 3, -1, 0, 0);
      idle(2);
      run_seq(0, 'h020, 4, -1, 1, 0);
      run_seq(1, 'h030, 4, -1, 1, 0);
      idle(2);
      run_seq(1, 'h040, 3, -1, 0, 1);
      run_seq(1, 'h040, 3, -1, 0, 0);
      idle(1);
      for (int i = 0; i < 24; i++) begin
         run_seq(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 6)),
                 -1, 1'($urandom_range(0, 1)), 0);
         idle(int'($urandom_range(0, 2)));
      end
      idle(6);
      check(q_rd.size() == 0 && q_ld.size() == 0 && q_dn.size() == 0,
            $sformatf("drain got pending rd=%0d ld=%0d done=%0d required 0 0 0", q_rd.size(), q_ld.size(), q_dn.size()));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
